gate_exerciser: RTL and testbench
=================================

# gate_exerciser

Self-checking stimulus stage that drives the A/B inputs of a two-input combinational gate under test (default reference behaviour: Y = A & B) and checks the returned Y. On a START pulse it applies N_VECTORS input vectors, one per cycle. The first four vectors are an exhaustive sweep; the rest are LFSR-generated. It counts mismatches and reports PASS/DONE. It sits directly upstream of the gate in gate-level test harnesses and consumes the gate's output in the same cycle.

## Interface
Parameters:
- N_VECTORS, 16, number of vectors per run; legal range 1..255.
- LFSR_SEED, 8'hA5, LFSR seed loaded on each accepted START; a value of 0 is replaced by 8'h01.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset; one clock.
- START  input  1  run request; sampled only in IDLE.
- Y  input  1  gate output; combinational function of A and B.
- A  output  1  gate input A (registered).
- B  output  1  gate input B (registered).
- BUSY  output  1  high in RUN.
- DONE  output  1  one-cycle pulse in the DONE state.
- ERR_CNT  output  8  mismatch count for the last run; saturates at 255.
- PASS  output  1  high when ERR_CNT == 0; valid while DONE is high and held until the next accepted START.

## Operation
- States:
  - IDLE: A=B=0, BUSY=0. START=1 causes the following on the next edge: go to RUN, clear ERR_CNT, set vec_idx=0, load the LFSR with the seed, drive vector 0.
  - RUN: one vector per cycle. On each edge, compare Y against A & B. On mismatch, ERR_CNT increments, saturating at 255. On the edge where vec_idx == N_VECTORS-1, go to DONE; otherwise load the next vector and increment vec_idx.
  - DONE: one cycle. DONE=1, A=B=0. Go to IDLE unconditionally.
- Vector source:
  - vec_idx 0..3: {B,A} = vec_idx[1:0], giving 00, 01, 10, 11.
  - vec_idx >= 4: {B,A} = lfsr[1:0].
  - LFSR is an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shift-left, feedback into bit 0.
  - The LFSR advances once per RUN cycle, starting with the first RUN cycle.
- If N_VECTORS < 4, only the first N_VECTORS sweep vectors are applied.
- vec_idx width is 8 bits.
- START is ignored in RUN and DONE; it is neither queued nor restarted.
- Holding START=1 continuously starts a new run every N_VECTORS+2 cycles.
- PASS = (ERR_CNT == 0). It is combinational from ERR_CNT.

## Timing
- Reset values: A=0, B=0, BUSY=0, DONE=0, ERR_CNT=0, PASS=1, state=IDLE, LFSR=seed.
- Reset asserted mid-run aborts immediately and asynchronously to the reset values. No DONE pulse is produced.
- START sampled high at edge t:
  - BUSY=1 and vector 0 on A/B after edge t.
  - Vector k is valid during the cycle after edge t+k.
  - Y is checked at edge t+k+1.
  - DONE=1 during the cycle after edge t+N_VECTORS, with BUSY=0 in that cycle.
  - Back in IDLE after edge t+N_VECTORS+1.
- Total run latency from START to the DONE pulse is N_VECTORS+1 cycles.
- ERR_CNT updated at the final compare edge is visible in the DONE cycle.
- The gate must settle within one cycle. Y is not registered in this block.

## Test plan
- Reset and idle: assert RST mid-cycle with START=0. Required: A=B=0, BUSY=0, DONE=0, ERR_CNT=0, PASS=1. Reset is released synchronously to the bench and outputs stay stable.
- Exhaustive sweep, correct gate (N_VECTORS=4): pulse START. Required:
  - {B,A} = 00, 01, 10, 11 on 4 consecutive cycles.
  - DONE pulses 5 cycles after START is sampled.
  - ERR_CNT=0, PASS=1.
- Faulty gate (Y tied to A | B, N_VECTORS=4): Required: ERR_CNT=2 (vectors 01 and 10), PASS=0 at DONE.
- LFSR run (N_VECTORS=16, seed 8'hA5, Y stuck at 0): Required: ERR_CNT equals the number of applied vectors with A=B=1 (the bench model computes this from the LFSR sequence). A second START reproduces the identical A/B sequence and count.
- Saturation (N_VECTORS=255, Y = ~(A&B)): Required: ERR_CNT=255, no wrap, PASS=0.
- Robustness: pulse START during RUN and during DONE, which must be ignored. Assert RST at vector 5, which must give an immediate return to reset values with no DONE pulse. A subsequent START runs normally.

Source files
------------

// File: rtl/gate_exerciser.sv
// gate_exerciser: drives A/B of a two-input gate under test and checks the
// returned Y against A & B. Each run applies N_VECTORS vectors, one per cycle:
// an exhaustive 00/01/10/11 sweep first, then LFSR-generated vectors. Mismatches
// are counted (saturating at 255) and reported through ERR_CNT/PASS with a
// one-cycle DONE pulse.
module gate_exerciser #(
    parameter int           N_VECTORS = 16,
    parameter logic [7:0]   LFSR_SEED = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        Y,
    output logic        A,
    output logic        B,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  ERR_CNT,
    output logic        PASS
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] LAST_IDX = 8'(N_VECTORS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_vec_idx;
    logic [7:0]  r_lfsr;
    logic        r_a;
    logic        r_b;
    logic [7:0]  r_err_cnt;

    logic        w_start_run;
    logic        w_in_run;
    logic        w_last;
    logic        w_mismatch;
    logic        w_lfsr_fb;
    logic [7:0]  w_lfsr_next;
    logic [7:0]  w_next_idx;
    logic [1:0]  w_next_vec;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_lfsr_next = {r_lfsr[6:0], w_lfsr_fb};

    // Vector k is shown in the same cycle the LFSR holds its k-th advanced value,
    // so vectors past the sweep take their bits from the value being loaded.
    assign w_next_idx = r_vec_idx + 8'd1;
    assign w_next_vec = (w_next_idx < 8'd4) ? w_next_idx[1:0] : w_lfsr_next[1:0];

    assign w_last     = (r_vec_idx == LAST_IDX);
    // Y is a same-cycle combinational response to the registered A/B.
    assign w_mismatch = (Y != (r_a & r_b));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-state control strobes.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start_run  = 1'b0;
        w_in_run     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_next = S_RUN;
                    w_start_run  = 1'b1;
                end
            end
            S_RUN: begin
                w_in_run = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Vector generation, LFSR stepping and mismatch counting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vec_idx <= 8'd0;
            r_lfsr    <= SEED_EFF;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_err_cnt <= 8'd0;
        end else if (w_start_run) begin
            // Vector 0 of the sweep is 00.
            r_vec_idx <= 8'd0;
            r_lfsr    <= SEED_EFF;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_err_cnt <= 8'd0;
        end else if (w_in_run) begin
            r_lfsr <= w_lfsr_next;
            if (w_mismatch && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_last) begin
                // Park the gate inputs low for the DONE cycle.
                r_a <= 1'b0;
                r_b <= 1'b0;
            end else begin
                r_vec_idx  <= w_next_idx;
                {r_b, r_a} <= w_next_vec;
            end
        end else begin
            r_a <= 1'b0;
            r_b <= 1'b0;
        end
    end

    assign A       = r_a;
    assign B       = r_b;
    assign BUSY    = (r_state == S_RUN);
    assign DONE    = (r_state == S_DONE);
    assign ERR_CNT = r_err_cnt;
    assign PASS    = (r_err_cnt == 8'd0);

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: four instances with different vector counts and
// seeds, each driving a gate modelled by a per-instance truth table. Expected
// vectors and error counts come from a reference model of the vector rules.
module tb_gate_exerciser;

    localparam int         N_OF    [4] = '{4, 16, 255, 1};
    localparam logic [7:0] SEED_OF [4] = '{8'hA5, 8'hA5, 8'h00, 8'h3C};

    // Gate truth tables indexed by {B,A}.
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_ZERO  = 4'b0000;
    localparam logic [3:0] TT_NAND  = 4'b0111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start   [4];
    logic       y       [4];
    logic       a       [4];
    logic       b       [4];
    logic       busy    [4];
    logic       done    [4];
    logic [7:0] err_cnt [4];
    logic       pass    [4];
    logic [3:0] tt      [4];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0] exp_vec       [256];
    int         exp_err_after [257];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_gate
        assign y[g] = tt[g][{b[g], a[g]}];
    end

    gate_exerciser #(.N_VECTORS(N_OF[0]), .LFSR_SEED(SEED_OF[0])) dut0 (
        .CLK(clk), .RST(rst), .START(start[0]), .Y(y[0]), .A(a[0]), .B(b[0]),
        .BUSY(busy[0]), .DONE(done[0]), .ERR_CNT(err_cnt[0]), .PASS(pass[0]));
    gate_exerciser #(.N_VECTORS(N_OF[1]), .LFSR_SEED(SEED_OF[1])) dut1 (
        .CLK(clk), .RST(rst), .START(start[1]), .Y(y[1]), .A(a[1]), .B(b[1]),
        .BUSY(busy[1]), .DONE(done[1]), .ERR_CNT(err_cnt[1]), .PASS(pass[1]));
    gate_exerciser #(.N_VECTORS(N_OF[2]), .LFSR_SEED(SEED_OF[2])) dut2 (
        .CLK(clk), .RST(rst), .START(start[2]), .Y(y[2]), .A(a[2]), .B(b[2]),
        .BUSY(busy[2]), .DONE(done[2]), .ERR_CNT(err_cnt[2]), .PASS(pass[2]));
    gate_exerciser #(.N_VECTORS(N_OF[3]), .LFSR_SEED(SEED_OF[3])) dut3 (
        .CLK(clk), .RST(rst), .START(start[3]), .Y(y[3]), .A(a[3]), .B(b[3]),
        .BUSY(busy[3]), .DONE(done[3]), .ERR_CNT(err_cnt[3]), .PASS(pass[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Reference: vector k is k for k<4, else bits [1:0] of the seed advanced k
    // times. exp_err_after[k] is the saturated mismatch count over vectors 0..k-1.
    task automatic build_model(input int d, input int n, input logic [7:0] seed);
        logic [7:0] s;
        int         errs;
        s    = (seed == 8'h00) ? 8'h01 : seed;
        errs = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) s = lfsr_step(s);
            exp_vec[k]       = (k < 4) ? 2'(k) : s[1:0];
            exp_err_after[k] = errs;
            if (tt[d][exp_vec[k]] != (exp_vec[k][1] & exp_vec[k][0]))
                errs = (errs < 255) ? errs + 1 : 255;
        end
        exp_err_after[n] = errs;
    endtask

    task automatic check_reset_values(input int d, input string tag);
        check({tag, "_busy"}, busy[d], 1'b0);
        check({tag, "_done"}, done[d], 1'b0);
        check({tag, "_a"},    a[d],    1'b0);
        check({tag, "_b"},    b[d],    1'b0);
        check({tag, "_err"},  err_cnt[d], 8'd0);
        check({tag, "_pass"}, pass[d], 1'b1);
    endtask

    // Called on a negedge. START is sampled at the next posedge (edge t);
    // every observation is made on the negedge after edge t+k.
    task automatic run(input int d, input bit hold, input bit noise, input int abort_at,
                       input string tag);
        int n;
        n = N_OF[d];
        build_model(d, n, SEED_OF[d]);
        start[d] = 1'b1;
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!hold) start[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            check($sformatf("%s_busy_v%0d", tag, k), busy[d], 1'b1);
            check($sformatf("%s_done_v%0d", tag, k), done[d], 1'b0);
            check($sformatf("%s_ba_v%0d", tag, k), {b[d], a[d]}, exp_vec[k]);
            check($sformatf("%s_err_v%0d", tag, k), err_cnt[d], exp_err_after[k]);
            check($sformatf("%s_pass_v%0d", tag, k), pass[d], exp_err_after[k] == 0);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_values(d, $sformatf("%s_abort", tag));
                start[d] = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check($sformatf("%s_abort_nodone_%0d", tag, c), done[d], 1'b0);
                    check($sformatf("%s_abort_idle_%0d", tag, c), busy[d], 1'b0);
                end
                return;
            end
        end
        @(negedge clk);
        check({tag, "_done"},      done[d], 1'b1);
        check({tag, "_done_busy"}, busy[d], 1'b0);
        check({tag, "_done_ba"},   {b[d], a[d]}, 2'b00);
        check({tag, "_done_err"},  err_cnt[d], exp_err_after[n]);
        check({tag, "_done_pass"}, pass[d], exp_err_after[n] == 0);
        if (!hold) start[d] = noise;
        @(negedge clk);
        check({tag, "_idle_done"}, done[d], 1'b0);
        check({tag, "_idle_busy"}, busy[d], 1'b0);
        check({tag, "_idle_err"},  err_cnt[d], exp_err_after[n]);
        check({tag, "_idle_pass"}, pass[d], exp_err_after[n] == 0);
        if (!hold) start[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 4; d++) begin
            start[d] = 1'b0;
            tt[d]    = TT_AND;
        end

        // Mid-cycle reset with START low, released on a bench negedge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) check_reset_values(d, $sformatf("rst%0d", d));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) check_reset_values(d, $sformatf("rel%0d_c%0d", d, c));
        end

        // Exhaustive sweep with a correct AND gate.
        run(0, 1'b0, 1'b0, -1, "sweep_and");
        // OR gate disagrees on 01 and 10.
        tt[0] = TT_OR;
        run(0, 1'b0, 1'b0, -1, "sweep_or");
        // START held high: runs back to back every N_VECTORS+2 cycles.
        tt[0] = TT_AND;
        run(0, 1'b1, 1'b0, -1, "hold1");
        run(0, 1'b1, 1'b0, -1, "hold2");
        start[0] = 1'b0;

        // LFSR run with Y stuck at 0; a second run must repeat the sequence,
        // this time with random START noise during RUN and DONE.
        tt[1] = TT_ZERO;
        run(1, 1'b0, 1'b0, -1, "lfsr_a");
        run(1, 1'b0, 1'b1, -1, "lfsr_b");
        // Random gate behaviours.
        for (int r = 0; r < 3; r++) begin
            tt[1] = 4'($urandom);
            run(1, 1'b0, 1'b1, -1, $sformatf("rand%0d", r));
        end

        // Saturation: every vector mismatches, zero seed replaced by 1.
        tt[2] = TT_NAND;
        run(2, 1'b0, 1'b1, -1, "sat");

        // Single-vector run.
        tt[3] = TT_NAND;
        run(3, 1'b0, 1'b0, -1, "n1");

        // Reset at vector 5, then a normal run.
        tt[1] = TT_ZERO;
        run(1, 1'b0, 1'b0, 5, "abort");
        run(1, 1'b0, 1'b0, -1, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
